dpe_result_collector: RTL and testbench
=======================================

// Module: dpe_result_collector
// PURPOSE
// Sink for the dot-product engine result stream (valid + 32-bit result, no backpressure).
// Sums i_num_chunks consecutive DPE results into one matrix-vector row value, so rows
// longer than one DPE width are supported. Completed rows are buffered in a FIFO and
// released on a valid/ready interface. An almost-full flag throttles the upstream feeder.
// PARAMETERS
// OPREC       32  width of DPE result (signed two's complement)
// ACCW        40  row accumulator / output width (signed); ACCW >= OPREC
// MAX_CHUNKS  16  max DPE results per row; CW = $clog2(MAX_CHUNKS)+1
// FIFO_DEPTH  8   completed-row buffer entries (power of 2)
// AF_MARGIN   2   o_almost_full when occupancy >= FIFO_DEPTH-AF_MARGIN
// IDXW        16  row index width
// PORTS
// clk          in   1      clock
// rst          in   1      asynchronous active-high reset
// i_num_chunks in   CW     results per row; sampled on first chunk of each row
// i_valid      in   1      DPE result valid
// i_result     in   OPREC  DPE result (signed)
// o_valid      out  1      FIFO head holds a completed row
// o_row        out  ACCW   row sum at FIFO head
// o_row_idx    out  IDXW   index of row at FIFO head
// i_ready      in   1      downstream accepts head when o_valid & i_ready
// o_almost_full out 1      occupancy >= FIFO_DEPTH-AF_MARGIN
// o_overflow   out  1      sticky: a completed row was dropped
// BEHAVIOUR
// - Reset (async, any time): all outputs 0; FIFO empty; chunk counter, accumulator,
//   row counter cleared; partial row discarded. Reset mid-row leaves no trace.
// - FSM: IDLE (cnt==0) / ACCUM (0<cnt<N). On i_valid in IDLE: latch N=i_num_chunks
//   (0 treated as 1; values >MAX_CHUNKS clamp to MAX_CHUNKS), acc<=sext(i_result).
//   On i_valid in ACCUM: acc<=acc+sext(i_result). i_num_chunks ignored mid-row.
// - Final chunk (cnt==N-1, incl. N==1): sum acc+sext(i_result) is pushed with current
//   row counter; row counter +1 (wraps at 2^IDXW); FSM -> IDLE. No i_valid = no change.
// - Latency: final chunk at edge k -> o_valid=1 with that row from cycle after edge k
//   when FIFO empty (first-word fall-through, one register stage).
// - FIFO: pop when o_valid & i_ready. Push when full accepted only if pop same cycle;
//   push+pop on empty not allowed to bypass (push lands, o_valid next cycle).
// - Overflow: push when full with no pop -> row dropped, row counter still increments,
//   o_overflow=1 until rst. o_row/o_row_idx are 0 while o_valid=0.
// - o_almost_full registered from occupancy; updates cycle after push/pop.
// - Arithmetic: signed, sign-extend OPREC->ACCW; default wraps modulo 2^ACCW.
// CONFIGURATION
// DPE_COLLECT_SAT_EN defined: each accumulate saturates to [-2^(ACCW-1), 2^(ACCW-1)-1];
//   extra sticky output o_saturated (1 bit, reset 0) set on any clamped add.
// Undefined: two's complement wrap, no o_saturated port.
// TESTING
// 1 N=1, one i_result=64 -> next cycle o_valid=1, o_row=64, o_row_idx=0; pop, o_valid=0.
// 2 N=4, results 64,64,-10,2 back-to-back -> single row o_row=120, idx 0; no row earlier.
// 3 i_ready=0, N=1, 9 results 1..9 -> o_almost_full after 6th, rows 1..8 held,
//   9th dropped, o_overflow=1; drain gives 1..8 with idx 0..7.
// 4 Full FIFO, i_ready=1 and new final chunk same cycle -> push accepted, no overflow.
// 5 N=4, two chunks then rst pulse, then N=1 result 5 -> o_row=5, o_row_idx=0.
// 6 ACCW=32, N=2, 0x7FFFFFFF twice -> o_row=0xFFFFFFFE (wrap); with DPE_COLLECT_SAT_EN
//   o_row=0x7FFFFFFF, o_saturated=1.

Source files
------------

// File: rtl/dpe_result_collector.sv
// ---------------------------------------------------------------------------
// dpe_result_collector
//
// Collects the dot-product engine result stream and adds up i_num_chunks
// consecutive results into one matrix-vector row value, so a row may be
// longer than one DPE width. Completed rows, each tagged with a running row
// index, go into a small FIFO and leave on a valid/ready interface. The
// almost-full flag lets the upstream feeder slow down before rows are lost.
//
// Build option:
//   DPE_COLLECT_SAT_EN  defined   -> every accumulate saturates to the signed
//                                    ACCW range; extra sticky o_saturated port
//                       undefined -> two's complement wrap, no o_saturated
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   i_num_chunks   in   results per row, sampled on the first chunk of a row
//                       (0 acts as 1, values above MAX_CHUNKS clamp)
//   i_valid        in   DPE result valid (no backpressure)
//   i_result       in   DPE result, signed OPREC bits
//   o_valid        out  FIFO head holds a completed row
//   o_row          out  row sum at FIFO head (0 while o_valid is low)
//   o_row_idx      out  row index at FIFO head (0 while o_valid is low)
//   i_ready        in   downstream takes the head when o_valid & i_ready
//   o_almost_full  out  occupancy >= FIFO_DEPTH-AF_MARGIN (registered)
//   o_overflow     out  sticky, a completed row was dropped
//   o_saturated    out  sticky, an accumulate was clamped (option only)
// ---------------------------------------------------------------------------
module dpe_result_collector #(
    parameter int OPREC      = 32,
    parameter int ACCW       = 40,
    parameter int MAX_CHUNKS = 16,
    parameter int CW         = $clog2(MAX_CHUNKS) + 1,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 2,
    parameter int IDXW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    i_num_chunks,
    input  logic             i_valid,
    input  logic [OPREC-1:0] i_result,
    output logic             o_valid,
    output logic [ACCW-1:0]  o_row,
    output logic [IDXW-1:0]  o_row_idx,
    input  logic             i_ready,
    output logic             o_almost_full,
    output logic             o_overflow
`ifdef DPE_COLLECT_SAT_EN
    ,
    output logic             o_saturated
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   N_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0]   N_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   N_MAX     = CW'(MAX_CHUNKS);
    localparam logic [AW-1:0]   PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]   PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] CNT_AF    = CNTW'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [ACCW-1:0] ACC_ZERO  = {ACCW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ZERO  = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE   = {{(IDXW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_n;
    logic [ACCW-1:0]   r_acc;
    logic [IDXW-1:0]   r_row_cnt;

    logic [CW-1:0]     w_n_new;
    logic              w_last;
    logic [ACCW-1:0]   w_acc_base;
    logic [ACCW-1:0]   w_ext;
    logic [ACCW-1:0]   w_sum;

    logic [ACCW-1:0]   r_mem_row [FIFO_DEPTH];
    logic [IDXW-1:0]   r_mem_idx [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNTW-1:0]   r_count;

    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic [CNTW-1:0]   w_count_nxt;
    logic [CNTW-1:0]   w_after_pop;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic              w_head_valid;
    logic [ACCW-1:0]   w_head_row;
    logic [IDXW-1:0]   w_head_idx;

    logic              r_valid;
    logic [ACCW-1:0]   r_row;
    logic [IDXW-1:0]   r_row_idx;
    logic              r_almost_full;
    logic              r_overflow;

    // Sign-extend the incoming DPE result to the accumulator width.
    assign w_ext = ACCW'($signed(i_result));

`ifdef DPE_COLLECT_SAT_EN
    logic              w_sat_hit;
    logic              r_saturated;

    // Signed add with clamp; MSB of the return value flags a clamped result.
    function automatic logic [ACCW:0] sat_add(input logic [ACCW-1:0] a,
                                              input logic [ACCW-1:0] b);
        logic [ACCW:0] s;
        logic [ACCW:0] r;
        s = {a[ACCW-1], a} + {b[ACCW-1], b};
        if (s[ACCW] != s[ACCW-1]) begin
            if (s[ACCW]) begin
                r = {1'b1, 1'b1, {(ACCW-1){1'b0}}};
            end else begin
                r = {1'b1, 1'b0, {(ACCW-1){1'b1}}};
            end
        end else begin
            r = {1'b0, s[ACCW-1:0]};
        end
        return r;
    endfunction

    assign {w_sat_hit, w_sum} = sat_add(w_acc_base, w_ext);
`else
    assign w_sum = w_acc_base + w_ext;
`endif

    // Row length for a row that starts on this cycle: 0 acts as 1, clamp to max.
    always_comb begin
        if (i_num_chunks == N_ZERO) begin
            w_n_new = N_ONE;
        end else if (i_num_chunks > N_MAX) begin
            w_n_new = N_MAX;
        end else begin
            w_n_new = i_num_chunks;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a row opens on a non-final chunk, closes on its final chunk.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid && !w_last) begin
                    w_state_nxt = S_ACCUM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: adder base (fresh row starts from zero) and final-chunk detect.
    always_comb begin
        w_acc_base = ACC_ZERO;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_acc_base = ACC_ZERO;
                w_last     = i_valid && (w_n_new == N_ONE);
            end
            S_ACCUM: begin
                w_acc_base = r_acc;
                w_last     = i_valid && (r_cnt == (r_n - N_ONE));
            end
            default: begin
                w_acc_base = ACC_ZERO;
                w_last     = 1'b0;
            end
        endcase
    end

    // Chunk counter, latched row length and partial-row accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= N_ZERO;
            r_n   <= N_ZERO;
            r_acc <= ACC_ZERO;
        end else if (i_valid) begin
            if (w_last) begin
                r_cnt <= N_ZERO;
                r_acc <= ACC_ZERO;
            end else begin
                r_cnt <= r_cnt + N_ONE;
                r_acc <= w_sum;
                if (r_state == S_IDLE) begin
                    r_n <= w_n_new;
                end
            end
        end
    end

    // Row index advances on every completed row, dropped rows included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_cnt <= IDX_ZERO;
        end else if (w_last) begin
            r_row_cnt <= r_row_cnt + IDX_ONE;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves this cycle.
    always_comb begin
        w_pop        = r_valid & i_ready;
        w_full       = (r_count == CNT_FULL);
        w_push       = w_last & (~w_full | w_pop);
        w_drop       = w_last & w_full & ~w_pop;
        w_after_pop  = w_pop ? (r_count - CNT_ONE) : r_count;
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
        if (w_push) begin
            w_count_nxt = w_after_pop + CNT_ONE;
        end else begin
            w_count_nxt = w_after_pop;
        end
    end

    // Next head of the FIFO; a row pushed into an empty slot becomes the head directly.
    always_comb begin
        w_head_valid = (w_count_nxt != CNT_ZERO);
        w_head_row   = ACC_ZERO;
        w_head_idx   = IDX_ZERO;
        if (!w_head_valid) begin
            w_head_row = ACC_ZERO;
            w_head_idx = IDX_ZERO;
        end else if (w_after_pop == CNT_ZERO) begin
            w_head_row = w_sum;
            w_head_idx = r_row_cnt;
        end else begin
            w_head_row = r_mem_row[w_rd_ptr_nxt];
            w_head_idx = r_mem_idx[w_rd_ptr_nxt];
        end
    end

    // FIFO storage; contents are only visible through the gated head registers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_row[r_wr_ptr] <= w_sum;
            r_mem_idx[r_wr_ptr] <= r_row_cnt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Registered output stage: head, almost-full level and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_row         <= ACC_ZERO;
            r_row_idx     <= IDX_ZERO;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_valid       <= w_head_valid;
            r_row         <= w_head_row;
            r_row_idx     <= w_head_idx;
            r_almost_full <= (w_count_nxt >= CNT_AF);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef DPE_COLLECT_SAT_EN
    // Sticky record of any clamped accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_saturated <= 1'b0;
        end else if (i_valid && w_sat_hit) begin
            r_saturated <= 1'b1;
        end
    end

    assign o_saturated = r_saturated;
`endif

    assign o_valid       = r_valid;
    assign o_row         = r_row;
    assign o_row_idx     = r_row_idx;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_dpe_result_collector.sv
module tb_dpe_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  i_num_chunks = 5'd0;
    logic        i_valid = 1'b0;
    logic [31:0] i_result = 32'd0;
    logic        i_ready = 1'b0;

    logic        o_valid;
    logic [39:0] o_row;
    logic [15:0] o_row_idx;
    logic        o_almost_full;
    logic        o_overflow;

    logic        n_valid;
    logic [31:0] n_row;
    logic [15:0] n_row_idx;
    logic        n_almost_full;
    logic        n_overflow;

`ifdef DPE_COLLECT_SAT_EN
    logic        o_saturated;
    logic        n_saturated;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpe_result_collector dut (
        .clk(clk), .rst(rst), .i_num_chunks(i_num_chunks), .i_valid(i_valid),
        .i_result(i_result), .o_valid(o_valid), .o_row(o_row), .o_row_idx(o_row_idx),
        .i_ready(i_ready), .o_almost_full(o_almost_full), .o_overflow(o_overflow)
`ifdef DPE_COLLECT_SAT_EN
        , .o_saturated(o_saturated)
`endif
    );

    // Narrow-accumulator instance for the wrap / saturation corner.
    dpe_result_collector #(.ACCW(32)) dut32 (
        .clk(clk), .rst(rst), .i_num_chunks(i_num_chunks), .i_valid(i_valid),
        .i_result(i_result), .o_valid(n_valid), .o_row(n_row), .o_row_idx(n_row_idx),
        .i_ready(i_ready), .o_almost_full(n_almost_full), .o_overflow(n_overflow)
`ifdef DPE_COLLECT_SAT_EN
        , .o_saturated(n_saturated)
`endif
    );

    typedef struct {
        logic [4:0]        n;
        logic [4:0]        n_mid;
        int                nch;
        logic [15:0][31:0] res;
        logic [39:0]       exp_row;
    } vec_t;

    typedef struct {
        logic [39:0] row;
        logic [15:0] idx;
    } row_t;

    vec_t tv[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_row", {24'd0, o_row}, 64'd0);
        chk("rst_idx", {48'd0, o_row_idx}, 64'd0);
        chk("rst_af", {63'd0, o_almost_full}, 64'd0);
        chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] v);
        i_num_chunks = 5'd1;
        i_valid = 1'b1;
        i_result = v;
        tick();
        i_valid = 1'b0;
    endtask

    // Reference model state (row-level view of the collector).
    row_t        mq[$];
    int          m_cnt;
    int          m_n;
    logic [39:0] m_acc;
    logic [15:0] m_rowcnt;
    logic        m_ovf;

    task automatic model_step();
        logic do_pop;
        do_pop = (mq.size() > 0) && i_ready;
        if (do_pop) void'(mq.pop_front());
        if (i_valid) begin
            if (m_cnt == 0) begin
                m_n = (i_num_chunks == 5'd0) ? 1 : ((i_num_chunks > 5'd16) ? 16 : int'(i_num_chunks));
                m_acc = 40'd0;
            end
            m_acc = m_acc + {{8{i_result[31]}}, i_result};
            m_cnt++;
            if (m_cnt == m_n) begin
                if (mq.size() < 8) mq.push_back('{row: m_acc, idx: m_rowcnt});
                else m_ovf = 1'b1;
                m_rowcnt = m_rowcnt + 16'd1;
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        // Table of whole rows: {N, N driven after the first chunk, chunks, values, sum}.
        for (int i = 0; i < 6; i++) begin
            tv[i].res = '0;
            tv[i].n_mid = 5'd1;
        end
        tv[0].n = 5'd1;  tv[0].nch = 1;  tv[0].res[0] = 32'd64;  tv[0].exp_row = 40'd64;
        tv[1].n = 5'd4;  tv[1].nch = 4;
        tv[1].res[0] = 32'd64; tv[1].res[1] = 32'd64; tv[1].res[2] = -32'sd10; tv[1].res[3] = 32'd2;
        tv[1].exp_row = 40'd120;
        tv[2].n = 5'd0;  tv[2].nch = 1;  tv[2].res[0] = -32'sd5;  tv[2].exp_row = 40'hFF_FFFF_FFFB;
        tv[3].n = 5'd31; tv[3].nch = 16;
        for (int c = 0; c < 16; c++) tv[3].res[c] = 32'h7FFF_FFFF;
        tv[3].exp_row = 40'h07_FFFF_FFF0;
        tv[4].n = 5'd2;  tv[4].nch = 2;
        tv[4].res[0] = 32'h8000_0000; tv[4].res[1] = 32'h8000_0000; tv[4].exp_row = 40'hFF_0000_0000;
        tv[5].n = 5'd3;  tv[5].nch = 3;  tv[5].n_mid = 5'd1;
        tv[5].res[0] = 32'd1; tv[5].res[1] = 32'd2; tv[5].res[2] = 32'd3; tv[5].exp_row = 40'd6;

        #3;
        do_reset();
        tick();
        chk("idle_valid", {63'd0, o_valid}, 64'd0);

        // Table-driven rows, ready held high, row index increments per row.
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_num_chunks = tv[i].n;
            for (int c = 0; c < tv[i].nch; c++) begin
                i_valid = 1'b1;
                i_result = tv[i].res[c];
                tick();
                if (c == 0) i_num_chunks = tv[i].n_mid;
                if (c < tv[i].nch - 1) chk("tv_early_valid", {63'd0, o_valid}, 64'd0);
            end
            i_valid = 1'b0;
            chk("tv_valid", {63'd0, o_valid}, 64'd1);
            chk("tv_row", {24'd0, o_row}, {24'd0, tv[i].exp_row});
            chk("tv_idx", {48'd0, o_row_idx}, 64'(i));
            tick();
            chk("tv_popped", {63'd0, o_valid}, 64'd0);
            chk("tv_row_zero", {24'd0, o_row}, 64'd0);
        end

        // Fill past capacity with no consumer: 8 held, 9th dropped.
        do_reset();
        i_ready = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            push_one(32'(j));
            chk("fill_af", {63'd0, o_almost_full}, (j >= 6) ? 64'd1 : 64'd0);
            chk("fill_head", {24'd0, o_row}, 64'd1);
            chk("fill_ovf", {63'd0, o_overflow}, (j >= 9) ? 64'd1 : 64'd0);
        end
        i_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_valid", {63'd0, o_valid}, 64'd1);
            chk("drain_row", {24'd0, o_row}, 64'(j + 1));
            chk("drain_idx", {48'd0, o_row_idx}, 64'(j));
            tick();
        end
        chk("drain_empty", {63'd0, o_valid}, 64'd0);
        chk("drain_af", {63'd0, o_almost_full}, 64'd0);
        chk("drain_ovf_sticky", {63'd0, o_overflow}, 64'd1);

        // Full FIFO with a pop and a final chunk in the same cycle.
        do_reset();
        i_ready = 1'b0;
        for (int j = 0; j < 8; j++) push_one(32'(11 + j));
        i_ready = 1'b1;
        push_one(32'd100);
        chk("full_swap_ovf", {63'd0, o_overflow}, 64'd0);
        for (int j = 0; j < 8; j++) begin
            chk("swap_valid", {63'd0, o_valid}, 64'd1);
            chk("swap_row", {24'd0, o_row}, (j == 7) ? 64'd100 : 64'(12 + j));
            chk("swap_idx", {48'd0, o_row_idx}, 64'(j + 1));
            tick();
        end
        chk("swap_empty", {63'd0, o_valid}, 64'd0);

        // Reset in the middle of a row leaves nothing behind.
        i_num_chunks = 5'd4;
        i_valid = 1'b1;
        i_result = 32'd7;
        tick();
        tick();
        do_reset();
        push_one(32'd5);
        chk("midrst_valid", {63'd0, o_valid}, 64'd1);
        chk("midrst_row", {24'd0, o_row}, 64'd5);
        chk("midrst_idx", {48'd0, o_row_idx}, 64'd0);
        tick();

        // Narrow accumulator: wrap in the default build, clamp with the option.
        do_reset();
        i_num_chunks = 5'd2;
        i_valid = 1'b1;
        i_result = 32'h7FFF_FFFF;
        tick();
        tick();
        i_valid = 1'b0;
        chk("n32_valid", {63'd0, n_valid}, 64'd1);
`ifdef DPE_COLLECT_SAT_EN
        chk("n32_row_sat", {32'd0, n_row}, 64'h7FFF_FFFF);
        chk("n32_saturated", {63'd0, n_saturated}, 64'd1);
        chk("wide_not_saturated", {63'd0, o_saturated}, 64'd0);
`else
        chk("n32_row_wrap", {32'd0, n_row}, 64'hFFFF_FFFE);
`endif
        tick();

        // Randomized traffic against the row-level model.
        do_reset();
        mq.delete();
        m_cnt = 0;
        m_n = 1;
        m_acc = 40'd0;
        m_rowcnt = 16'd0;
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int ready_pct;
            int sel;
            ready_pct = ((cyc / 500) % 3 == 1) ? 10 : (((cyc / 500) % 3 == 2) ? 50 : 90);
            sel = $urandom_range(0, 9);
            i_num_chunks = (sel == 9) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            i_valid = ($urandom_range(0, 3) != 0);
            i_result = (sel < 5) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
            i_ready = ($urandom_range(0, 99) < ready_pct);
            model_step();
            tick();
            chk("rnd_valid", {63'd0, o_valid}, (mq.size() > 0) ? 64'd1 : 64'd0);
            chk("rnd_row", {24'd0, o_row}, (mq.size() > 0) ? {24'd0, mq[0].row} : 64'd0);
            chk("rnd_idx", {48'd0, o_row_idx}, (mq.size() > 0) ? {48'd0, mq[0].idx} : 64'd0);
            chk("rnd_af", {63'd0, o_almost_full}, (mq.size() >= 6) ? 64'd1 : 64'd0);
            chk("rnd_ovf", {63'd0, o_overflow}, {63'd0, m_ovf});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
